// File: rtl/mcpu_bus_ctrl.sv
// rtl/mcpu_bus_ctrl.sv - CPU-to-device bus controller with per-region waits, enables, write protect (optional error capture: MCPU_BUS_CTRL_ERR_EN)
module mcpu_bus_ctrl #(
    parameter int                         DATA_WIDTH  = 16,
    parameter int                         ADDR_WIDTH  = 16,
    parameter int                         NUM_REGIONS = 4,
    parameter logic [4*NUM_REGIONS-1:0]   REGION_WAIT = '0,
    parameter logic [NUM_REGIONS-1:0]     REGION_EN   = '1,
    parameter logic [NUM_REGIONS-1:0]     REGION_WP   = '0
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          cpu_req,
    input  logic                                          cpu_we,
    input  logic [ADDR_WIDTH-1:0]                         cpu_addr,
    input  logic [DATA_WIDTH-1:0]                         cpu_wdata,
    output logic [DATA_WIDTH-1:0]                         cpu_rdata,
    output logic                                          cpu_ready,
    output logic                                          cpu_busy,
    output logic [NUM_REGIONS-1:0]                        dev_sel,
    output logic                                          dev_we,
    output logic [ADDR_WIDTH-$clog2(NUM_REGIONS)-1:0]     dev_addr,
    output logic [DATA_WIDTH-1:0]                         dev_wdata,
    input  logic [NUM_REGIONS*DATA_WIDTH-1:0]             dev_rdata,
    output logic                                          bus_err,
    output logic [ADDR_WIDTH-1:0]                         err_addr,
    input  logic                                          err_clr
);

    localparam int RB = $clog2(NUM_REGIONS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;

    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_we;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_cpu_rdata;
    logic [3:0]              r_wait;

    logic [RB-1:0]           w_req_region;
    logic [RB-1:0]           w_cur_region;
    logic                    w_accept;
    logic                    w_fault;
    logic [3:0]              w_load_wait;
    logic [DATA_WIDTH-1:0]   w_dev_slice;
    logic [NUM_REGIONS-1:0]  w_onehot;

    assign w_req_region = cpu_addr[ADDR_WIDTH-1 -: RB];
    assign w_cur_region = r_addr[ADDR_WIDTH-1 -: RB];
    assign w_accept     = (r_state == S_IDLE) && cpu_req;
    assign w_fault      = !REGION_EN[w_req_region] || (cpu_we && REGION_WP[w_req_region]);
    assign w_onehot     = {{(NUM_REGIONS-1){1'b0}}, 1'b1} << w_cur_region;

    // Select the wait count for the incoming region and the read slice for the latched region
    always_comb begin
        w_load_wait = '0;
        w_dev_slice = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (w_req_region == RB'(i)) begin
                w_load_wait = REGION_WAIT[i*4 +: 4];
            end
            if (w_cur_region == RB'(i)) begin
                w_dev_slice = dev_rdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state logic: faults skip ACCESS entirely so the device never sees them
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (cpu_req) begin
                    w_next_state = w_fault ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (r_wait == 4'd0) begin
                    w_next_state = S_RESP;
                end
            end
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Request latch, wait countdown and read-data capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_cpu_rdata <= '0;
            r_wait      <= 4'd0;
        end else if (w_accept) begin
            r_addr  <= cpu_addr;
            r_we    <= cpu_we;
            r_wdata <= cpu_wdata;
            r_wait  <= w_fault ? 4'd0 : w_load_wait;
            if (w_fault && !cpu_we) begin
                r_cpu_rdata <= '0;
            end
        end else if (r_state == S_ACCESS) begin
            if (r_wait != 4'd0) begin
                r_wait <= r_wait - 4'd1;
            end else if (!r_we) begin
                r_cpu_rdata <= w_dev_slice;
            end
        end
    end

    assign cpu_rdata = r_cpu_rdata;
    assign cpu_ready = (r_state == S_RESP);
    assign cpu_busy  = (r_state != S_IDLE);
    assign dev_sel   = (r_state == S_ACCESS) ? w_onehot : '0;
    assign dev_we    = (r_state == S_ACCESS) && r_we;
    assign dev_addr  = r_addr[ADDR_WIDTH-RB-1:0];
    assign dev_wdata = r_wdata;

`ifdef MCPU_BUS_CTRL_ERR_EN
    logic                  r_bus_err;
    logic [ADDR_WIDTH-1:0] r_err_addr;

    // Sticky error capture: keeps the first fault address; a fault beats a same-cycle clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bus_err  <= 1'b0;
            r_err_addr <= '0;
        end else if (w_accept && w_fault) begin
            r_bus_err <= 1'b1;
            if (!r_bus_err || err_clr) begin
                r_err_addr <= cpu_addr;
            end
        end else if (err_clr) begin
            r_bus_err  <= 1'b0;
            r_err_addr <= '0;
        end
    end

    assign bus_err  = r_bus_err;
    assign err_addr = r_err_addr;
`else
    logic w_unused_err_clr;

    assign w_unused_err_clr = err_clr;
    assign bus_err          = 1'b0;
    assign err_addr         = '0;
`endif

endmodule

// File: tb/tb_mcpu_bus_ctrl.sv
// tb/tb_mcpu_bus_ctrl.sv - directed self-checking bench for mcpu_bus_ctrl
module tb_mcpu_bus_ctrl;

`ifdef MCPU_BUS_CTRL_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        req;
    logic        req2;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [63:0] dev_rdata;
    logic        err_clr;

    logic [15:0] rdata,    rdata2;
    logic        ready,    ready2;
    logic        busy,     busy2;
    logic [3:0]  sel,      sel2;
    logic        dwe,      dwe2;
    logic [13:0] daddr,    daddr2;
    logic [15:0] dwdata,   dwdata2;
    logic        bus_err,  bus_err2;
    logic [15:0] err_addr, err_addr2;

    int n_pass;
    int n_total;

    int          lat;
    int          sel_cnt;
    int          we_cnt;
    logic [3:0]  sel_or;
    logic [13:0] addr_seen;
    logic [15:0] wd_seen;

    mcpu_bus_ctrl #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (16),
        .NUM_REGIONS(4),
        .REGION_WAIT(16'h0310),
        .REGION_EN  (4'b0111),
        .REGION_WP  (4'b0010)
    ) dut (
        .clk(clk), .reset(reset), .cpu_req(req), .cpu_we(we), .cpu_addr(addr),
        .cpu_wdata(wdata), .cpu_rdata(rdata), .cpu_ready(ready), .cpu_busy(busy),
        .dev_sel(sel), .dev_we(dwe), .dev_addr(daddr), .dev_wdata(dwdata),
        .dev_rdata(dev_rdata), .bus_err(bus_err), .err_addr(err_addr), .err_clr(err_clr)
    );

    mcpu_bus_ctrl #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (16),
        .NUM_REGIONS(4),
        .REGION_WAIT(16'h000F),
        .REGION_EN  (4'b1111),
        .REGION_WP  (4'b0000)
    ) dut_w15 (
        .clk(clk), .reset(reset), .cpu_req(req2), .cpu_we(we), .cpu_addr(addr),
        .cpu_wdata(wdata), .cpu_rdata(rdata2), .cpu_ready(ready2), .cpu_busy(busy2),
        .dev_sel(sel2), .dev_we(dwe2), .dev_addr(daddr2), .dev_wdata(dwdata2),
        .dev_rdata(dev_rdata), .bus_err(bus_err2), .err_addr(err_addr2), .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request to the main instance (called just after a negedge with it in IDLE)
    task automatic run_req(input logic i_we, input logic [15:0] i_addr, input logic [15:0] i_wdata);
        lat       = 0;
        sel_cnt   = 0;
        we_cnt    = 0;
        sel_or    = 4'b0000;
        addr_seen = '0;
        wd_seen   = '0;
        req   = 1'b1;
        we    = i_we;
        addr  = i_addr;
        wdata = i_wdata;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (sel != 4'b0000) begin
                sel_cnt++;
                sel_or    = sel_or | sel;
                addr_seen = daddr;
                wd_seen   = dwdata;
            end
            if (dwe) we_cnt++;
            if (ready) begin
                lat = k;
                break;
            end
        end
        req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        n_total++; if (ready !== 1'b0)      $display("FAIL reset_ready got %b want 0", ready);          else n_pass++;
        n_total++; if (busy !== 1'b0)       $display("FAIL reset_busy got %b want 0", busy);            else n_pass++;
        n_total++; if (sel !== 4'b0000)     $display("FAIL reset_sel got %b want 0000", sel);           else n_pass++;
        n_total++; if (dwe !== 1'b0)        $display("FAIL reset_dev_we got %b want 0", dwe);           else n_pass++;
        n_total++; if (rdata !== 16'h0000)  $display("FAIL reset_rdata got %h want 0000", rdata);       else n_pass++;
        n_total++; if (daddr !== 14'h0000)  $display("FAIL reset_dev_addr got %h want 0000", daddr);    else n_pass++;
        n_total++; if (dwdata !== 16'h0000) $display("FAIL reset_dev_wdata got %h want 0000", dwdata);  else n_pass++;
        n_total++; if (bus_err !== 1'b0)    $display("FAIL reset_bus_err got %b want 0", bus_err);      else n_pass++;
        n_total++; if (err_addr !== 16'h0)  $display("FAIL reset_err_addr got %h want 0000", err_addr); else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read_w0();
        run_req(1'b0, 16'h0005, 16'h0000);
        n_total++; if (lat !== 2)          $display("FAIL rd0_latency got %0d want 2", lat);          else n_pass++;
        n_total++; if (sel_cnt !== 1)      $display("FAIL rd0_sel_cycles got %0d want 1", sel_cnt);   else n_pass++;
        n_total++; if (sel_or !== 4'b0001) $display("FAIL rd0_sel got %b want 0001", sel_or);         else n_pass++;
        n_total++; if (addr_seen !== 14'h0005) $display("FAIL rd0_dev_addr got %h want 0005", addr_seen); else n_pass++;
        n_total++; if (we_cnt !== 0)       $display("FAIL rd0_dev_we got %0d want 0", we_cnt);        else n_pass++;
        n_total++; if (rdata !== 16'h1234) $display("FAIL rd0_rdata got %h want 1234", rdata);        else n_pass++;
    endtask

    task automatic test_write_wait3();
        run_req(1'b1, 16'h8010, 16'hBEEF);
        n_total++; if (lat !== 5)          $display("FAIL wr2_latency got %0d want 5", lat);          else n_pass++;
        n_total++; if (sel_cnt !== 4)      $display("FAIL wr2_sel_cycles got %0d want 4", sel_cnt);   else n_pass++;
        n_total++; if (sel_or !== 4'b0100) $display("FAIL wr2_sel got %b want 0100", sel_or);         else n_pass++;
        n_total++; if (we_cnt !== 4)       $display("FAIL wr2_we_cycles got %0d want 4", we_cnt);     else n_pass++;
        n_total++; if (wd_seen !== 16'hBEEF) $display("FAIL wr2_wdata got %h want beef", wd_seen);    else n_pass++;
        n_total++; if (addr_seen !== 14'h0010) $display("FAIL wr2_dev_addr got %h want 0010", addr_seen); else n_pass++;
        n_total++; if (rdata !== 16'h1234) $display("FAIL wr2_rdata_hold got %h want 1234", rdata);   else n_pass++;
    endtask

    task automatic test_read_region1();
        run_req(1'b0, 16'h4003, 16'h0000);
        n_total++; if (lat !== 3)          $display("FAIL rd1_latency got %0d want 3", lat);          else n_pass++;
        n_total++; if (sel_or !== 4'b0010) $display("FAIL rd1_sel got %b want 0010", sel_or);         else n_pass++;
        n_total++; if (rdata !== 16'h1111) $display("FAIL rd1_rdata got %h want 1111", rdata);        else n_pass++;
    endtask

    task automatic test_wp_fault();
        run_req(1'b1, 16'h4000, 16'hAAAA);
        n_total++; if (lat !== 1)     $display("FAIL wp_latency got %0d want 1", lat);        else n_pass++;
        n_total++; if (sel_cnt !== 0) $display("FAIL wp_sel_cycles got %0d want 0", sel_cnt); else n_pass++;
        n_total++; if (we_cnt !== 0)  $display("FAIL wp_we_cycles got %0d want 0", we_cnt);  else n_pass++;
        n_total++; if (bus_err !== ERR_ON) $display("FAIL wp_bus_err got %b want %b", bus_err, ERR_ON); else n_pass++;
        n_total++; if (err_addr !== (ERR_ON ? 16'h4000 : 16'h0000))
            $display("FAIL wp_err_addr got %h want %h", err_addr, ERR_ON ? 16'h4000 : 16'h0000); else n_pass++;
        run_req(1'b1, 16'h4002, 16'h5555);
        n_total++; if (lat !== 1)     $display("FAIL wp2_latency got %0d want 1", lat);       else n_pass++;
        n_total++; if (err_addr !== (ERR_ON ? 16'h4000 : 16'h0000))
            $display("FAIL wp2_err_addr_kept got %h want %h", err_addr, ERR_ON ? 16'h4000 : 16'h0000); else n_pass++;
    endtask

    task automatic test_disabled_read();
        run_req(1'b0, 16'hC000, 16'h0000);
        n_total++; if (lat !== 1)          $display("FAIL dis_latency got %0d want 1", lat);        else n_pass++;
        n_total++; if (sel_cnt !== 0)      $display("FAIL dis_sel_cycles got %0d want 0", sel_cnt); else n_pass++;
        n_total++; if (rdata !== 16'h0000) $display("FAIL dis_rdata got %h want 0000", rdata);     else n_pass++;
        err_clr = 1'b1;
        #1;
        n_total++; if (bus_err !== ERR_ON) $display("FAIL clr_before_edge got %b want %b", bus_err, ERR_ON); else n_pass++;
        @(negedge clk);
        err_clr = 1'b0;
        n_total++; if (bus_err !== 1'b0)   $display("FAIL clr_bus_err got %b want 0", bus_err);     else n_pass++;
        n_total++; if (err_addr !== 16'h0) $display("FAIL clr_err_addr got %h want 0000", err_addr); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int rc[3];
        int nready;
        int scnt;
        int bad;
        nready = 0;
        scnt   = 0;
        bad    = 0;
        rc     = '{0, 0, 0};
        req  = 1'b1;
        we   = 1'b0;
        addr = 16'h8000;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (sel != 4'b0000) begin
                scnt++;
                if (sel !== 4'b0100) bad++;
            end
            if (ready) begin
                rc[nready] = k;
                nready++;
                if (nready == 3) break;
            end
        end
        req = 1'b0;
        @(negedge clk);
        n_total++; if (nready !== 3) $display("FAIL b2b_ready_count got %0d want 3", nready); else n_pass++;
        n_total++; if (rc[0] !== 5)  $display("FAIL b2b_ready0 got %0d want 5", rc[0]);      else n_pass++;
        n_total++; if (rc[1] !== 11) $display("FAIL b2b_ready1 got %0d want 11", rc[1]);     else n_pass++;
        n_total++; if (rc[2] !== 17) $display("FAIL b2b_ready2 got %0d want 17", rc[2]);     else n_pass++;
        n_total++; if (scnt !== 12)  $display("FAIL b2b_sel_cycles got %0d want 12", scnt);  else n_pass++;
        n_total++; if (bad !== 0)    $display("FAIL b2b_sel_value got %0d bad want 0", bad); else n_pass++;
        n_total++; if (rdata !== 16'h2222) $display("FAIL b2b_rdata got %h want 2222", rdata); else n_pass++;
    endtask

    task automatic test_reset_abort();
        int rdy_seen;
        int busy_seen;
        rdy_seen  = 0;
        busy_seen = 0;
        req2 = 1'b1;
        we   = 1'b0;
        addr = 16'h0000;
        for (int k = 1; k <= 8; k++) @(negedge clk);
        n_total++; if (sel2 !== 4'b0001) $display("FAIL abort_sel_pre got %b want 0001", sel2); else n_pass++;
        n_total++; if (busy2 !== 1'b1)   $display("FAIL abort_busy_pre got %b want 1", busy2);  else n_pass++;
        reset = 1'b0;
        #1;
        n_total++; if (sel2 !== 4'b0000) $display("FAIL abort_sel_drop got %b want 0000", sel2); else n_pass++;
        n_total++; if (busy2 !== 1'b0)   $display("FAIL abort_busy_drop got %b want 0", busy2);  else n_pass++;
        req2 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (ready2) rdy_seen++;
            if (busy2)  busy_seen++;
        end
        n_total++; if (rdy_seen !== 0)  $display("FAIL abort_ready got %0d pulses want 0", rdy_seen); else n_pass++;
        n_total++; if (busy_seen !== 0) $display("FAIL abort_idle got %0d busy cycles want 0", busy_seen); else n_pass++;
        n_total++; if (rdata !== 16'h0000) $display("FAIL abort_main_rdata got %h want 0000", rdata); else n_pass++;
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        reset     = 1'b0;
        req       = 1'b0;
        req2      = 1'b0;
        we        = 1'b0;
        addr      = 16'h0000;
        wdata     = 16'h0000;
        err_clr   = 1'b0;
        dev_rdata = {16'h3333, 16'h2222, 16'h1111, 16'h1234};
        @(negedge clk);
        @(negedge clk);
        test_reset();
        test_read_w0();
        test_write_wait3();
        test_read_region1();
        test_wp_fault();
        test_disabled_read();
        test_back_to_back();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mcpu_bus_ctrl.md
MCPU_BUS_CTRL -- requirements
Module: mcpu_bus_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_WIDTH, 16, data bus width.
- ADDR_WIDTH, 16, CPU address width.
- NUM_REGIONS, 4, region count; power of 2, 2..16.
- REGION_WAIT, {NUM_REGIONS{4'd0}}, 4-bit wait count per region, packed, region 0 in LSBs.
- REGION_EN, all ones, per-region enable mask.
- REGION_WP, 0, per-region write-protect mask.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge.
- reset, in, 1, asynchronous, active-low.
- cpu_req, in, 1, access request.
- cpu_we, in, 1, 1 = write.
- cpu_addr, in, ADDR_WIDTH, CPU address.
- cpu_wdata, in, DATA_WIDTH, write data.
- cpu_rdata, out, DATA_WIDTH, registered read data.
- cpu_ready, out, 1, one-cycle completion pulse.
- cpu_busy, out, 1, high while the controller is not in IDLE.
- dev_sel, out, NUM_REGIONS, one-hot region select.
- dev_we, out, 1, device write strobe.
- dev_addr, out, ADDR_WIDTH-RB, in-region offset (RB = log2(NUM_REGIONS)).
- dev_wdata, out, DATA_WIDTH, device write data.
- dev_rdata, in, NUM_REGIONS*DATA_WIDTH, packed device read data.
- bus_err, out, 1, sticky error flag (macro only).
- err_addr, out, ADDR_WIDTH, first faulting address (macro only).
- err_clr, in, 1, clears the error (macro only).

Function
REQ-003 Region index SHALL be cpu_addr[ADDR_WIDTH-1 -: RB].
REQ-004 The FSM SHALL have states IDLE, ACCESS, RESP.
REQ-005 In IDLE with cpu_req=1, the block SHALL latch addr, we and wdata into registers. Next state:
- ACCESS, for an enabled region whose access is legal.
- RESP, for a disabled region or a write to a write-protected region (a "fault").
REQ-006 In ACCESS, dev_sel SHALL be one-hot for the latched region, dev_addr/dev_wdata SHALL be driven from the latched values, and dev_we SHALL equal the latched we.
- A wait counter SHALL load REGION_WAIT[region] on entry and decrement each cycle.
REQ-007 When the counter is 0 in ACCESS:
- on a read, the dev_rdata slice of that region SHALL be captured into cpu_rdata;
- the next state SHALL be RESP.
REQ-008 In RESP, cpu_ready SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-009 Latency from the cpu_req sample edge to cpu_ready high SHALL be:
- W+2 cycles for a legal access, where W = REGION_WAIT[region];
- 1 cycle for a fault.
REQ-010 A faulted read SHALL return cpu_rdata=0; a faulted write SHALL never assert dev_sel or dev_we.
REQ-011 cpu_req SHALL be sampled only in IDLE; it is ignored in ACCESS and RESP. The CPU holds req until ready; a new request is accepted at the earliest in the cycle after RESP.
REQ-012 Outside ACCESS, dev_sel and dev_we SHALL be 0.
REQ-013 cpu_rdata SHALL hold its value until the next completed read.
REQ-014 The wait counter SHALL never wrap: a W of 15 yields exactly 16 ACCESS cycles.

Reset
REQ-015 When reset=0, asynchronously: state=IDLE, cpu_rdata=0, cpu_ready=0, dev_sel=0, dev_we=0, dev_addr=0, dev_wdata=0, counter=0, bus_err=0, err_addr=0.
REQ-016 Reset asserted mid-ACCESS SHALL abort the access: dev_we is removed immediately and no cpu_ready is issued after release.

Configuration
REQ-017 Macro MCPU_BUS_CTRL_ERR_EN SHALL control error capture.
- Defined: on every fault, bus_err is set. err_addr captures cpu_addr only if bus_err was 0, so the first fault is kept.
- Defined: err_clr=1 clears bus_err and err_addr on the next edge. A fault in the same cycle as err_clr takes priority and is captured.
- Undefined: bus_err and err_addr SHALL be tied to 0 and err_clr SHALL be ignored. Fault handling per REQ-010 is unchanged.

Verification
REQ-018 Read region 0 with W=0, dev_rdata slice0=16'h1234, addr=16'h0005:
- dev_sel=4'b0001 and dev_addr=14'h0005 for 1 cycle;
- cpu_ready 2 cycles after the req edge, with cpu_rdata=16'h1234.
REQ-019 Write region 2 with REGION_WAIT[2]=3, addr=16'h8010, wdata=16'hBEEF:
- dev_sel=4'b0100, dev_we=1, dev_wdata=16'hBEEF held for 4 cycles;
- cpu_ready at cycle 5.
REQ-020 Write to region 1 with REGION_WP[1]=1, macro defined:
- dev_sel stays 0 throughout;
- cpu_ready at cycle 1;
- bus_err=1, err_addr=16'h4000.
- A second fault to 16'h4002 leaves err_addr=16'h4000.
REQ-021 Read of disabled region 3 (REGION_EN[3]=0), then err_clr pulse:
- cpu_rdata=0 with ready at cycle 1;
- bus_err returns to 0 the cycle after err_clr.
REQ-022 Read of region 0 with W=15: reset=0 asserted in the 8th ACCESS cycle drops dev_sel the same cycle; after release, cpu_ready stays 0 and the FSM is in IDLE.
REQ-023 cpu_req held high continuously: ready pulses occur every W+3 cycles, with no overlapping dev_sel.
